tk1_cpu_mon: RTL
================

// Module: tk1_cpu_mon
// PURPOSE
//  Parametrised CPU execution monitor for the tk1 control core: NUM_WIN lockable address windows plus a fixed FW RAM window.
//  Forces a trap on any instruction fetch inside an armed window, latches the first offending address, counts violations and
//  blinks the trap LED. Sits between the PicoRV32 bus snoop and the tk1 API decoder; tk1 forwards its 0x60-0x7f space here.
// PARAMETERS
//  NUM_WIN      4            number of programmable windows, 1..8
//  FW_RAM_FIRST 32'hd0000000 first address of the always-protected FW RAM window
//  FW_RAM_LAST  32'hd00007ff last address of the always-protected FW RAM window
//  BLINK_BITS   24           trap LED toggles when the free-running blink counter wraps (period 2^BLINK_BITS clk)
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   asynchronous active-low reset
//  cpu_addr     in   32  CPU bus address
//  cpu_instr    in   1   access is an instruction fetch
//  cpu_valid    in   1   CPU bus access valid
//  cpu_trap     in   1   CPU trap status
//  force_trap   out  1   combinational trap request to CPU
//  trap_led     out  3   LED override {r,g,b}, valid while cpu_trap=1
//  cs           in   1   register select
//  we           in   1   write enable
//  address      in   5   word address within block
//  write_data   in   32  write data
//  read_data    out  32  read data, 0 when not selected or unmapped
//  ready        out  1   = cs, same cycle
// BEHAVIOUR
//  Reset: all regs 0, FSM DISABLED, force_trap=0, trap_led=0, read_data=0, ready=0.
//  Map: 0x00 CTRL (W: bit0=1 arms & locks), 0x01 STATUS (R: [0] viol, [1] locked, [15:8] count; W any: clear viol/count if !locked),
//   0x02 VIOL_ADDR (R), 0x03 NUM_WIN (R), 0x10+2i WIN_FIRST[i], 0x11+2i WIN_LAST[i], i<NUM_WIN; others read 0, writes ignored.
//  FSM: DISABLED -(CTRL write bit0=1)-> ARMED -(window match)-> TRAPPED; TRAPPED exits only on reset. No path back to DISABLED.
//  Lock: locked=1 in ARMED/TRAPPED; window, CTRL and STATUS writes then ignored; ready still asserted.
//  Match: cpu_valid & cpu_instr & first<=addr<=last, unsigned, inclusive. Window with first>last matches nothing.
//  FW window checked in every state; programmable windows only in ARMED/TRAPPED.
//  force_trap: combinational, same cycle as the matching access, zero latency.
//  Capture: on first match (viol=0), VIOL_ADDR<=cpu_addr and viol<=1 next edge; later matches leave VIOL_ADDR unchanged.
//  Count: 8-bit; +1 per cycle with force_trap=1; saturates at 0xff.
//  FW-window match in DISABLED sets viol and count but does not change FSM state.
//  Simultaneous STATUS clear and match: match wins, viol=1, count=1.
//  Blink: counter always runs. On wrap with cpu_trap=1, trap_led toggles bit2 (red). trap_led clears to 0 when cpu_trap=0.
//  Reset mid-operation: asynchronous, returns all state to reset values immediately.
// CONFIGURATION
//  CPU_MON_DATA_EN defined: also trap data accesses (cpu_valid & !cpu_instr) in programmable windows while ARMED/TRAPPED,
//   i.e. full no-access windows. FW window stays fetch-only.
//  Undefined: only instruction fetches are checked. NUM_WIN readback bit8 = 1 when macro defined.
// TESTING
//  T1 fetch 0xd0000004 after reset -> force_trap=1 same cycle; VIOL_ADDR=0xd0000004, count=1; FSM stays DISABLED.
//  T2 win0=[0x40001000,0x40001fff], CTRL=1, fetch 0x40001fff -> force_trap=1, TRAPPED; fetch 0x40002000 -> force_trap=0.
//  T3 after arming, write win0 first=0, STATUS clear -> readback unchanged, locked=1, ready=1 on each access.
//  T4 win1 first=0x100 last=0x80, armed, fetch 0x90 -> no trap; 300 violating fetches -> count=0xff.
//  T5 CPU_MON_DATA_EN: armed window, data read in window -> force_trap=1; without macro -> force_trap=0.
//  T6 BLINK_BITS=4, cpu_trap=1 -> trap_led toggles 3'h4/3'h0 every 16 clk; reset_n low mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/tk1_cpu_mon.sv
// CPU execution monitor: lockable fetch-trap windows plus a fixed FW RAM window, violation capture and trap LED blink.
// Optional CPU_MON_DATA_EN also traps data accesses inside the programmable windows.
module tk1_cpu_mon #(
    parameter int          NUM_WIN      = 4,
    parameter logic [31:0] FW_RAM_FIRST = 32'hd0000000,
    parameter logic [31:0] FW_RAM_LAST  = 32'hd00007ff,
    parameter int          BLINK_BITS   = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_instr,
    input  logic        cpu_valid,
    input  logic        cpu_trap,
    output logic        force_trap,
    output logic [2:0]  trap_led,
    input  logic        cs,
    input  logic        we,
    input  logic [4:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready
);

`ifdef CPU_MON_DATA_EN
    localparam logic DATA_EN = 1'b1;
`else
    localparam logic DATA_EN = 1'b0;
`endif

    localparam logic [4:0] ADDR_CTRL   = 5'h00;
    localparam logic [4:0] ADDR_STATUS = 5'h01;
    localparam logic [4:0] ADDR_VADDR  = 5'h02;
    localparam logic [4:0] ADDR_NWIN   = 5'h03;

    typedef enum logic [1:0] {ST_DISABLED, ST_ARMED, ST_TRAPPED} state_t;

    state_t                state_q, state_d;
    logic [31:0]           win_first_q [NUM_WIN];
    logic [31:0]           win_first_d [NUM_WIN];
    logic [31:0]           win_last_q  [NUM_WIN];
    logic [31:0]           win_last_d  [NUM_WIN];
    logic [31:0]           viol_addr_q, viol_addr_d;
    logic                  viol_q, viol_d;
    logic [7:0]            count_q, count_d;
    logic [BLINK_BITS-1:0] blink_q, blink_d;
    logic [2:0]            trap_led_q, trap_led_d;

    logic locked, win_en, fw_hit, win_hit, hit, reg_wr;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_DISABLED;
            viol_addr_q <= '0;
            viol_q      <= 1'b0;
            count_q     <= '0;
            blink_q     <= '0;
            trap_led_q  <= '0;
            for (int i = 0; i < NUM_WIN; i++) begin
                win_first_q[i] <= '0;
                win_last_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            viol_addr_q <= viol_addr_d;
            viol_q      <= viol_d;
            count_q     <= count_d;
            blink_q     <= blink_d;
            trap_led_q  <= trap_led_d;
            win_first_q <= win_first_d;
            win_last_q  <= win_last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DISABLED: if (reg_wr && address == ADDR_CTRL && write_data[0]) state_d = ST_ARMED;
            ST_ARMED:    if (hit) state_d = ST_TRAPPED;
            default:     state_d = ST_TRAPPED;
        endcase
    end

    always_comb begin
        locked = (state_q == ST_ARMED) || (state_q == ST_TRAPPED);
        win_en = locked;
    end

    always_comb begin
        fw_hit  = cpu_valid && cpu_instr && (cpu_addr >= FW_RAM_FIRST) && (cpu_addr <= FW_RAM_LAST);
        win_hit = 1'b0;
        for (int i = 0; i < NUM_WIN; i++) begin
            if (win_en && cpu_valid && (cpu_instr || DATA_EN) &&
                (cpu_addr >= win_first_q[i]) && (cpu_addr <= win_last_q[i]))
                win_hit = 1'b1;
        end
        hit    = fw_hit || win_hit;
        reg_wr = cs && we && !locked;
    end

    always_comb begin
        win_first_d = win_first_q;
        win_last_d  = win_last_q;
        viol_addr_d = viol_addr_q;
        viol_d      = viol_q;
        count_d     = count_q;
        for (int i = 0; i < NUM_WIN; i++) begin
            if (reg_wr && address == 5'(16 + 2 * i)) win_first_d[i] = write_data;
            if (reg_wr && address == 5'(17 + 2 * i)) win_last_d[i]  = write_data;
        end
        // A match in the same cycle as a STATUS clear restarts the count at one.
        if (hit) begin
            viol_d = 1'b1;
            if (!viol_q) viol_addr_d = cpu_addr;
            count_d = (reg_wr && address == ADDR_STATUS) ? 8'd1 : sat_inc(count_q);
        end else if (reg_wr && address == ADDR_STATUS) begin
            viol_d  = 1'b0;
            count_d = '0;
        end
    end

    always_comb begin
        blink_d    = blink_q + {{(BLINK_BITS-1){1'b0}}, 1'b1};
        trap_led_d = trap_led_q;
        if (!cpu_trap)
            trap_led_d = '0;
        else if (blink_q == {BLINK_BITS{1'b1}})
            trap_led_d = {~trap_led_q[2], 2'b00};
    end

    always_comb begin
        read_data = '0;
        if (cs && reset_n) begin
            case (address)
                ADDR_STATUS: read_data = {16'd0, count_q, 6'd0, locked, viol_q};
                ADDR_VADDR:  read_data = viol_addr_q;
                ADDR_NWIN:   read_data = 32'(NUM_WIN) | {23'd0, DATA_EN, 8'd0};
                default: begin
                    for (int i = 0; i < NUM_WIN; i++) begin
                        if (address == 5'(16 + 2 * i)) read_data = win_first_q[i];
                        if (address == 5'(17 + 2 * i)) read_data = win_last_q[i];
                    end
                end
            endcase
        end
    end

    // Combinational outputs are gated by reset so an asserted reset silences them at once.
    assign force_trap = hit && reset_n;
    assign ready      = cs && reset_n;
    assign trap_led   = trap_led_q;

endmodule
